// File: rtl/btb_pkg.sv
// btb_pkg: shared types, counter encodings and geometry helpers for the BTB.
//   btb_entry_t  - one BTB entry (valid, tag, target, ctr); tag and target
//                  fields are BTB_ADDR_W wide, and narrower values are zero-extended.
//   CTR_*        - 2-bit direction counter states.
//   btb_idx_w / btb_tag_w - set-index and tag widths for a given geometry.
package btb_pkg;

   localparam int BTB_ADDR_W = 32;

   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;

   typedef struct packed {
      logic                  valid;
      logic [BTB_ADDR_W-1:0] tag;
      logic [BTB_ADDR_W-1:0] target;
      logic [1:0]            ctr;
   } btb_entry_t;

   function automatic int btb_idx_w(input int entries, input int ways);
      return $clog2(entries / ways);
   endfunction

   function automatic int btb_tag_w(input int addr_w, input int entries, input int ways);
      return addr_w - btb_idx_w(entries, ways) - 2;
   endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// btb_sat_ctr: 2-bit saturating direction counter next-state logic.
//   i_ctr   - current counter value
//   i_taken - resolved branch outcome
//   o_ctr   - next counter value (saturates at CTR_SNT / CTR_ST)
module btb_sat_ctr
   import btb_pkg::*;
(
   input  logic [1:0] i_ctr,
   input  logic       i_taken,
   output logic [1:0] o_ctr
);

   assign o_ctr = i_taken ? ((i_ctr == CTR_ST)  ? CTR_ST  : i_ctr + 2'd1)
                          : ((i_ctr == CTR_SNT) ? CTR_SNT : i_ctr - 2'd1);

endmodule

// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with 2-bit direction counters.
//   clk, reset (async, active-low)
//   pc -> pred_hit / pred_taken / pred_target : combinational fetch lookup
//   upd_valid, upd_pc, upd_taken, upd_target  : execute-stage training
//   flush                                     : invalidate all entries
// Optional macro BTB_FWD_EN: forward a same-cycle update on upd_pc == pc to the outputs.
module btb_assoc
   import btb_pkg::*;
#(
   parameter int         ADDR_W   = 32,
   parameter int         ENTRIES  = 16,
   parameter int         WAYS     = 2,
   parameter logic [1:0] CTR_INIT = 2'b10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              flush
);

   localparam int SETS  = ENTRIES / WAYS;
   localparam int IDX_W = btb_idx_w(ENTRIES, WAYS);
   localparam int TAG_W = btb_tag_w(ADDR_W, ENTRIES, WAYS);

   btb_entry_t r_ent [SETS][WAYS];

   logic [IDX_W-1:0]      w_idx, w_uidx;
   logic [TAG_W-1:0]      w_ptag, w_uptag;
   logic [BTB_ADDR_W-1:0] w_tag, w_utag;
   logic                  w_hit, w_htkn, w_uhit, w_uhway, w_vic, w_way, w_lru, w_we;
   logic [ADDR_W-1:0]     w_htgt, w_utgt;
   logic [1:0]            w_uctr, w_ctr_nxt;
   btb_entry_t            w_new;
   logic                  w_unused;

   assign w_idx   = pc[IDX_W+1:2];
   assign w_uidx  = upd_pc[IDX_W+1:2];
   assign w_ptag  = pc[ADDR_W-1:IDX_W+2];
   assign w_uptag = upd_pc[ADDR_W-1:IDX_W+2];
   assign w_tag   = BTB_ADDR_W'(w_ptag);
   assign w_utag  = BTB_ADDR_W'(w_uptag);
   // Byte offset within the instruction word plays no part in indexing or tagging.
   assign w_unused = ^{pc[1:0], upd_pc[1:0]};

   // Descending scan so way 0 wins a (never expected) double hit and the lowest invalid way is the victim.
   always_comb begin
      w_hit   = 1'b0;
      w_htkn  = 1'b0;
      w_htgt  = '0;
      w_uhit  = 1'b0;
      w_uhway = 1'b0;
      w_utgt  = '0;
      w_uctr  = '0;
      w_vic   = w_lru;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (r_ent[w_idx][i].valid && r_ent[w_idx][i].tag == w_tag) begin
            w_hit  = 1'b1;
            w_htkn = r_ent[w_idx][i].ctr[1];
            w_htgt = r_ent[w_idx][i].target[ADDR_W-1:0];
         end
         if (r_ent[w_uidx][i].valid && r_ent[w_uidx][i].tag == w_utag) begin
            w_uhit  = 1'b1;
            w_uhway = 1'(i);
            w_utgt  = r_ent[w_uidx][i].target[ADDR_W-1:0];
            w_uctr  = r_ent[w_uidx][i].ctr;
         end
         if (!r_ent[w_uidx][i].valid) w_vic = 1'(i);
      end
   end

   btb_sat_ctr u_ctr (
      .i_ctr   (w_uctr),
      .i_taken (upd_taken),
      .o_ctr   (w_ctr_nxt)
   );

   assign w_way = w_uhit ? w_uhway : w_vic;
   assign w_we  = upd_valid && !flush && (w_uhit || upd_taken);

   always_comb begin
      w_new.valid  = 1'b1;
      w_new.tag    = w_utag;
      w_new.target = BTB_ADDR_W'(upd_taken ? upd_target : w_utgt);
      w_new.ctr    = w_uhit ? w_ctr_nxt : CTR_INIT;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) r_ent[s][w] <= '0;
      end else if (flush) begin
         for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) r_ent[s][w].valid <= 1'b0;
      end else if (w_we) begin
         for (int w = 0; w < WAYS; w++)
            if (1'(w) == w_way) r_ent[w_uidx][w] <= w_new;
      end
   end

   if (WAYS == 2) begin : g_lru
      logic [SETS-1:0] r_lru;
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) r_lru <= '0;
         else if (w_we) r_lru[w_uidx] <= ~w_way;
      end
      assign w_lru = r_lru[w_uidx];
   end else begin : g_nolru
      assign w_lru = 1'b0;
   end

`ifdef BTB_FWD_EN
   logic w_fwd;
   assign w_fwd = upd_valid && !flush && (upd_pc == pc);
   // When forwarding, upd_pc == pc so the update-side counter is the looked-up entry's counter.
   always_comb begin
      pred_hit    = w_hit || (w_fwd && upd_taken);
      pred_taken  = w_fwd ? (upd_taken || (w_hit && w_ctr_nxt[1])) : (w_hit && w_htkn);
      pred_target = (w_fwd && upd_taken) ? upd_target : (w_hit ? w_htgt : '0);
   end
`else
   always_comb begin
      pred_hit    = w_hit;
      pred_taken  = w_hit && w_htkn;
      pred_target = w_hit ? w_htgt : '0;
   end
`endif

endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer with 2-bit saturating direction counters. Next generation of the fetch-stage BTB.
- Fetch-stage lookup is combinational on the current PC; training comes from the execute stage through an update port.
- Adds per-set LRU replacement, direction prediction, not-taken training and a global flush.
- Sits beside the PC register; its outputs feed the next-PC mux.

Parameters:
- ADDR_W, 32, width of PC and target addresses.
- ENTRIES, 16, total entries; power of two, at least 2*WAYS.
- WAYS, 2, associativity; legal values 1 or 2.
- CTR_INIT, 2'b10, counter value loaded on allocation (weakly taken).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  fetch PC to look up.
- pred_hit  out  1  a valid entry matches pc.
- pred_taken  out  1  pred_hit and counter[1] set.
- pred_target  out  ADDR_W  target of the matching entry; 0 when no hit.
- upd_valid  in  1  execute-stage branch resolved this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  branch outcome.
- upd_target  in  ADDR_W  resolved target.
- flush  in  1  invalidate all entries.

Behaviour:
- Geometry:
  - SETS = ENTRIES/WAYS; IDX_W = log2(SETS).
  - index = addr[IDX_W+1:2]; tag = addr[ADDR_W-1:IDX_W+2]; addr[1:0] ignored.
- Entry fields: valid, tag, target[ADDR_W-1:0], ctr[1:0]. Each set has one LRU bit, present only when WAYS==2.
- Reset (reset low, asynchronous): all valid=0, ctr=0, tag=0, target=0, LRU=0. Outputs are therefore pred_hit=0, pred_taken=0, pred_target=0 immediately.
- Lookup (combinational, zero latency):
  - Hit in a way when valid and tag match.
  - If both ways match (illegal, never created by the update rules), way 0 wins.
  - Lookups do not alter LRU.
- Update (rising edge, upd_valid=1), using the set and tag of upd_pc:
  - Hit, taken: ctr = min(ctr+1, 3); target = upd_target.
  - Hit, not taken: ctr = max(ctr-1, 0). Target and valid are unchanged; a counter at 0 stays valid.
  - Hit, either outcome: LRU points to the other way.
  - Miss, taken: allocate. Victim is the lowest-numbered invalid way; if none is invalid, the way named by LRU. Victim gets valid=1, tag, upd_target, ctr=CTR_INIT. LRU then points to the other way.
  - Miss, not taken: no state change.
- Flush (rising edge):
  - Clears all valid bits in one cycle; ctr, tag, target and LRU are unchanged.
  - flush and upd_valid in the same cycle: flush wins and the update is dropped.
- Simultaneous lookup and update to the same set: lookup returns pre-edge contents (see optional feature).
- Reset asserted mid-operation aborts any in-flight update; there is no partial write.
- WAYS==1: direct mapped, no LRU storage; a taken miss always replaces the single entry.

Optional Feature:
- Macro: BTB_FWD_EN.
- Defined: same-cycle update forwarding. When upd_valid=1, flush=0 and upd_pc==pc:
  - If upd_taken: pred_hit=1, pred_taken=1, pred_target=upd_target.
  - If not taken and the lookup hits: pred_taken reflects the decremented counter.
  - Adds a comparator and output muxing only; storage behaviour is identical.
- Undefined: outputs reflect stored state only; the update becomes visible the cycle after the edge.

Decomposition:
- Package btb_pkg:
  - typedef btb_entry_t (valid, tag, target, ctr).
  - Counter constants CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - Index/tag width helper functions.
- Sub-module btb_sat_ctr: combinational 2-bit saturating next-state (inputs ctr and taken; output next ctr). Instantiated once in the update path.

Test Plan (ENTRIES=16, WAYS=2: SETS=8, index=pc[4:2], tag=pc[31:5]):
- Reset, then lookup pc=0x0000_0100 -> pred_hit=0, pred_taken=0, pred_target=0.
- Update upd_pc=0x100, taken, target 0x200; next cycle pc=0x100 -> hit=1, taken=1 (ctr=2), target=0x200.
- Train 0x100 not-taken twice -> ctr=0, pred_hit=1, pred_taken=0. One taken update -> ctr=1, pred_taken=0. Second taken update -> ctr=2, pred_taken=1.
- Taken misses 0x100, 0x120, then 0x140 (all set 0):
  - 0x140 evicts 0x100 (LRU way).
  - Lookups: 0x120 hits, 0x100 misses.
- Assert flush with upd_valid=1 for 0x160 in the same cycle -> all lookups miss, and 0x160 stays absent afterwards.
- With BTB_FWD_EN: pc=upd_pc=0x180, taken, target 0x300 in one cycle -> same-cycle pred_hit=1, target=0x300. Without the macro -> pred_hit=0 that cycle and 1 the next.
